// File: rtl/sample_framer_if.sv
// sample_framer_if: sample-stream bundle around the framer.
//   ADC side      : valid, sample (to framer), ready (from framer)
//   Output side   : out_valid, out_data, out_first, out_last (from framer),
//                   out_ready (to framer)
// Modports:
//   master - environment side (ADC source + downstream sink)
//   slave  - the framer
interface sample_framer_if;
  logic       ready;
  logic       valid;
  logic [7:0] sample;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_first;
  logic       out_last;

  modport master (
    output valid, sample, out_ready,
    input  ready, out_valid, out_data, out_first, out_last
  );

  modport slave (
    input  valid, sample, out_ready,
    output ready, out_valid, out_data, out_first, out_last
  );
endinterface

// File: rtl/sample_framer.sv
// sample_framer: accepts offset-binary ADC samples, converts them to two's
// complement and groups them into N-sample frames tagged first/last, buffered
// through a DEPTH-entry FIFO toward the Goertzel core.
// Ports:
//   clk        - system clock, rising edge
//   nrst       - synchronous active-low reset
//   start      - pulse; starts capture when idle
//   cont       - continuous mode, sampled on a frame's last accepted sample
//   busy       - capture in progress
//   frame_done - one-cycle pulse after a frame's last sample is accepted
//   bus        - ADC input handshake and tagged output stream (slave side)
module sample_framer #(
  parameter int unsigned N     = 205,
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic            cont,
  output logic            busy,
  output logic            frame_done,
  sample_framer_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);

  // One FIFO entry: frame tags plus the signed sample.
  typedef struct packed {
    logic       first;
    logic       last;
    logic [7:0] data;
  } frame_word_t;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_CAPTURE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_done_q, frame_done_d;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  frame_word_t      mem [DEPTH];

  frame_word_t      wr_word;
  frame_word_t      head;
  logic             fifo_full;
  logic             ready_c;
  logic             out_valid_c;
  logic             in_xfer;
  logic             out_xfer;
  logic             last_in;

  // Handshake decode, derived only from registered state.
  assign fifo_full   = (count_q == CNT_FULL);
  assign ready_c     = (state_q == S_CAPTURE) && !fifo_full;
  assign out_valid_c = (count_q != '0);
  assign in_xfer     = bus.valid && ready_c;
  assign out_xfer    = out_valid_c && bus.out_ready;
  assign last_in     = (idx_q == IDX_LAST);

  // Incoming word: flipping the MSB maps offset-binary onto two's complement.
  always_comb begin
    wr_word       = '0;
    wr_word.first = (idx_q == '0);
    wr_word.last  = last_in;
    wr_word.data  = bus.sample ^ 8'h80;
  end

  assign head = mem[rd_ptr_q];

  // Head is masked while empty so the outputs read zero out of reset.
  assign bus.ready     = ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_valid_c ? head.data  : 8'h00;
  assign bus.out_first = out_valid_c ? head.first : 1'b0;
  assign bus.out_last  = out_valid_c ? head.last  : 1'b0;

  assign busy       = (state_q == S_CAPTURE);
  assign frame_done = frame_done_q;

  // Capture FSM: next state, sample index and frame_done pulse.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CAPTURE;
          idx_d   = '0;
        end
      end
      S_CAPTURE: begin
        if (in_xfer) begin
          if (last_in) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            if (!cont) begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // FIFO pointer/occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (in_xfer) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (out_xfer) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({in_xfer, out_xfer})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (nrst && in_xfer) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer with N=4, DEPTH=4. Inputs are driven and
// outputs sampled on the falling edge.
module tb_sample_framer;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic nrst;
  logic start;
  logic cont;
  logic busy;
  logic frame_done;

  int checks   = 0;
  int failures = 0;

  sample_framer_if bus ();

  sample_framer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .cont       (cont),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    start         = 1'b0;
    cont          = 1'b0;
    bus.valid     = 1'b0;
    bus.sample    = 8'h00;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    logic [13:0] obs;
    idle_inputs();
    nrst = 1'b0;
    tick();
    tick();
    obs = {bus.ready, bus.out_valid, busy, frame_done, bus.out_first, bus.out_last, bus.out_data};
    checks++;
    if (obs !== 14'h0) begin
      failures++;
      $display("FAIL reset_in got=%h exp=%h", obs, 14'h0);
    end
    nrst = 1'b1;
    tick();
    obs = {bus.ready, bus.out_valid, busy, frame_done, bus.out_first, bus.out_last, bus.out_data};
    checks++;
    if (obs !== 14'h0) begin
      failures++;
      $display("FAIL reset_after got=%h exp=%h", obs, 14'h0);
    end
  endtask

  task automatic test_single;
    logic [7:0] vin [4];
    logic [7:0] vexp [4];
    logic [4:0] obs, e;
    int fd;
    vin  = '{8'h00, 8'h80, 8'hFF, 8'h7F};
    vexp = '{8'h80, 8'h00, 8'h7F, 8'hFF};
    fd = 0;
    cont = 1'b0;
    bus.out_ready = 1'b1;
    pulse_start();
    checks++;
    if ({busy, bus.ready, bus.out_valid} !== 3'b110) begin
      failures++;
      $display("FAIL single_start got=%b exp=%b", {busy, bus.ready, bus.out_valid}, 3'b110);
    end
    for (int i = 0; i < 4; i++) begin
      bus.valid  = 1'b1;
      bus.sample = vin[i];
      tick();
      checks++;
      if (bus.out_data !== vexp[i]) begin
        failures++;
        $display("FAIL single_data[%0d] got=%h exp=%h", i, bus.out_data, vexp[i]);
      end
      obs = {bus.out_valid, bus.out_first, bus.out_last, frame_done, busy};
      e   = {1'b1, (i == 0), (i == 3), (i == 3), (i != 3)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL single_tags[%0d] got=%b exp=%b", i, obs, e);
      end
      if (frame_done) fd++;
    end
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready_end got=%b exp=0", bus.ready);
    end
    bus.valid = 1'b0;
    tick();
    checks++;
    if ({bus.out_valid, frame_done, bus.ready, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL single_drain got=%b exp=0000", {bus.out_valid, frame_done, bus.ready, busy});
    end
    checks++;
    if (fd !== 1) begin
      failures++;
      $display("FAIL single_fd_count got=%0d exp=1", fd);
    end
  endtask

  task automatic test_continuous;
    logic [7:0] s, e_data;
    logic [3:0] obs, e;
    int fd;
    fd = 0;
    cont = 1'b1;
    bus.out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      s          = 8'(i * 16 + 1);
      e_data     = s ^ 8'h80;
      bus.valid  = 1'b1;
      bus.sample = s;
      tick();
      checks++;
      if (bus.out_data !== e_data) begin
        failures++;
        $display("FAIL cont_data[%0d] got=%h exp=%h", i, bus.out_data, e_data);
      end
      obs = {bus.out_first, bus.out_last, frame_done, busy};
      e   = {(i % 4 == 0), (i % 4 == 3), (i % 4 == 3), 1'b1};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL cont_tags[%0d] got=%b exp=%b", i, obs, e);
      end
      if (frame_done) fd++;
    end
    bus.valid = 1'b0;
    tick();
    checks++;
    if ({busy, frame_done, bus.ready} !== 3'b101) begin
      failures++;
      $display("FAIL cont_after got=%b exp=101", {busy, frame_done, bus.ready});
    end
    checks++;
    if (fd !== 2) begin
      failures++;
      $display("FAIL cont_fd_count got=%0d exp=2", fd);
    end
  endtask

  task automatic test_back_pressure;
    logic e_ready;
    logic [9:0] obs, e;
    cont = 1'b1;
    bus.out_ready = 1'b0;
    pulse_start();
    for (int c = 0; c < 6; c++) begin
      e_ready = (c < 4);
      checks++;
      if (bus.ready !== e_ready) begin
        failures++;
        $display("FAIL bp_ready[%0d] got=%b exp=%b", c, bus.ready, e_ready);
      end
      bus.valid  = 1'b1;
      bus.sample = 8'(8'h10 + c);
      tick();
    end
    obs = {bus.ready, bus.out_valid, bus.out_data};
    e   = {1'b0, 1'b1, 8'h90};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL bp_full got=%h exp=%h", obs, e);
    end
    bus.valid     = 1'b0;
    bus.out_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      tick();
      obs = {bus.ready, bus.out_valid, 8'(8'h10 + j) ^ 8'h80};
      e   = {1'b1, 1'b1, bus.out_data};
      e   = {1'b1, 1'b1, 8'(8'h10 + j) ^ 8'h80};
      obs = {bus.ready, bus.out_valid, bus.out_data};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL bp_drain[%0d] got=%h exp=%h", j, obs, e);
      end
      checks++;
      if ({bus.out_first, bus.out_last} !== {1'b0, (j == 3)}) begin
        failures++;
        $display("FAIL bp_tags[%0d] got=%b exp=%b", j, {bus.out_first, bus.out_last}, {1'b0, (j == 3)});
      end
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e_data;
    logic [2:0] obs, e;
    cont = 1'b1;
    bus.out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      bus.valid  = 1'b1;
      bus.sample = 8'(i * 7 + 3);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bus.valid  = 1'b1;
      bus.sample = 8'((j + 2) * 7 + 3);
      tick();
      e_data = 8'((j + 1) * 7 + 3) ^ 8'h80;
      checks++;
      if (bus.out_data !== e_data) begin
        failures++;
        $display("FAIL b2b_data[%0d] got=%h exp=%h", j, bus.out_data, e_data);
      end
      obs = {bus.ready, bus.out_valid, bus.out_first};
      e   = {1'b1, 1'b1, ((j + 1) % 4 == 0)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL b2b_flags[%0d] got=%b exp=%b", j, obs, e);
      end
    end
    bus.valid = 1'b0;
    tick();
    e_data = 8'(21 * 7 + 3) ^ 8'h80;
    checks++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, e_data}) begin
      failures++;
      $display("FAIL b2b_tail got=%h exp=%h", {bus.out_valid, bus.out_data}, {1'b1, e_data});
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] e_data;
    logic [2:0] obs, e;
    cont = 1'b0;
    bus.out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      bus.valid  = 1'b1;
      bus.sample = 8'(8'h50 + i);
      tick();
    end
    bus.valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got=%b exp=1", bus.out_valid);
    end
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    checks++;
    if ({bus.out_valid, bus.ready, busy} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=000", {bus.out_valid, bus.ready, busy});
    end
    bus.out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      bus.valid  = 1'b1;
      bus.sample = 8'(8'hA0 + i);
      tick();
      e_data = 8'(8'hA0 + i) ^ 8'h80;
      checks++;
      if (bus.out_data !== e_data) begin
        failures++;
        $display("FAIL mid_data[%0d] got=%h exp=%h", i, bus.out_data, e_data);
      end
      obs = {bus.out_first, bus.out_last, frame_done};
      e   = {(i == 0), (i == 3), (i == 3)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mid_tags[%0d] got=%b exp=%b", i, obs, e);
      end
    end
    bus.valid = 1'b0;
  endtask

  task automatic test_start_ignored;
    logic [2:0] obs, e;
    cont = 1'b0;
    bus.out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      bus.valid  = 1'b1;
      bus.sample = 8'(8'h30 + i);
      start      = (i == 1) || (i == 2);
      tick();
      obs = {bus.out_first, bus.out_last, frame_done};
      e   = {(i == 0), (i == 3), (i == 3)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL ign_tags[%0d] got=%b exp=%b", i, obs, e);
      end
    end
    start     = 1'b0;
    bus.valid = 1'b0;
    checks++;
    if ({busy, bus.ready} !== 2'b00) begin
      failures++;
      $display("FAIL ign_end got=%b exp=00", {busy, bus.ready});
    end
    tick();
    checks++;
    if ({busy, bus.out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL ign_idle got=%b exp=00", {busy, bus.out_valid});
    end
  endtask

  initial begin
    nrst = 1'b0;
    idle_inputs();
    test_reset();
    do_reset();
    test_single();
    do_reset();
    test_continuous();
    do_reset();
    test_back_pressure();
    do_reset();
    test_back_to_back();
    do_reset();
    test_mid_reset();
    do_reset();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
